// File: rtl/wbq_pkg.sv
// Shared constants and packed-entry layout for the writeback commit queue.
// One entry: four result slots, then the operand size, then the ptcid.
package wbq_pkg;

   localparam int WBQ_DEPTH = 4;
   localparam int WBQ_PTR_W = 2;
   localparam int DATA_W    = 64;
   localparam int SEG_W     = 16;
   localparam int PTCID_W   = 7;
   localparam int ADDR_W    = 3;
   localparam int NSLOT     = 4;

   localparam int SLOT_W    = DATA_W + ADDR_W + 2;
   localparam int SLOT_DATA = 0;
   localparam int SLOT_ADDR = DATA_W;
   localparam int SLOT_SEG  = DATA_W + ADDR_W;
   localparam int SLOT_LD   = DATA_W + ADDR_W + 1;

   localparam int OPSIZE_LO = NSLOT * SLOT_W;
   localparam int PTCID_LO  = OPSIZE_LO + 2;
   localparam int ENTRY_W   = PTCID_LO + PTCID_W;

   function automatic int slot_base(input int s);
      return s * SLOT_W;
   endfunction

endpackage

// File: rtl/wbq_match.sv
// RAW check of one queued entry against the four GPR and four segment
// read addresses; a slot only matches reads of its own kind.
module wbq_match
   import wbq_pkg::*;
(
   input  logic [NSLOT*ADDR_W-1:0] addr,
   input  logic [NSLOT-1:0]        is_seg,
   input  logic [NSLOT-1:0]        ld,
   input  logic [NSLOT*ADDR_W-1:0] rd_regaddr,
   input  logic [NSLOT*ADDR_W-1:0] rd_segaddr,
   output logic                    hit
);

   always_comb begin
      hit = 1'b0;
      for (int s = 0; s < NSLOT; s++) begin
         for (int r = 0; r < NSLOT; r++) begin
            if (ld[s]) begin
               if (!is_seg[s] &&
                   addr[s*ADDR_W +: ADDR_W] == rd_regaddr[r*ADDR_W +: ADDR_W])
                  hit = 1'b1;
               if (is_seg[s] &&
                   addr[s*ADDR_W +: ADDR_W] == rd_segaddr[r*ADDR_W +: ADDR_W])
                  hit = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/wb_commit_queue.sv
// In-order writeback buffer between execute and the register/segment files,
// with a conservative forwarding-stall check against every queued write.
module wb_commit_queue
   import wbq_pkg::*;
#(
   parameter int DEPTH = WBQ_DEPTH,
   parameter int PTR_W = WBQ_PTR_W
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                valid_in,
   input  logic [DATA_W-1:0]   res_data1,
   input  logic [DATA_W-1:0]   res_data2,
   input  logic [DATA_W-1:0]   res_data3,
   input  logic [DATA_W-1:0]   res_data4,
   input  logic [ADDR_W-1:0]   res_addr1,
   input  logic [ADDR_W-1:0]   res_addr2,
   input  logic [ADDR_W-1:0]   res_addr3,
   input  logic [ADDR_W-1:0]   res_addr4,
   input  logic [NSLOT-1:0]    res_is_seg,
   input  logic [NSLOT-1:0]    res_ld,
   input  logic [1:0]          opsize_in,
   input  logic [PTCID_W-1:0]  ptcid_in,
   input  logic                flush,
   input  logic                wb_hold,
   input  logic [11:0]         rd_regaddr,
   input  logic [11:0]         rd_segaddr,
   input  logic                rd_valid,
   output logic                stall_out,
   output logic [DATA_W-1:0]   wb_data1,
   output logic [DATA_W-1:0]   wb_data2,
   output logic [DATA_W-1:0]   wb_data3,
   output logic [DATA_W-1:0]   wb_data4,
   output logic [SEG_W-1:0]    wb_segdata1,
   output logic [SEG_W-1:0]    wb_segdata2,
   output logic [SEG_W-1:0]    wb_segdata3,
   output logic [SEG_W-1:0]    wb_segdata4,
   output logic [ADDR_W-1:0]   wb_addr1,
   output logic [ADDR_W-1:0]   wb_addr2,
   output logic [ADDR_W-1:0]   wb_addr3,
   output logic [ADDR_W-1:0]   wb_addr4,
   output logic [ADDR_W-1:0]   wb_segaddr1,
   output logic [ADDR_W-1:0]   wb_segaddr2,
   output logic [ADDR_W-1:0]   wb_segaddr3,
   output logic [ADDR_W-1:0]   wb_segaddr4,
   output logic [1:0]          wb_opsize,
   output logic [NSLOT-1:0]    wb_regld,
   output logic [NSLOT-1:0]    wb_segld,
   output logic [PTCID_W-1:0]  wb_inst_ptcid,
   output logic                fwd_stall,
   output logic [PTR_W:0]      count
);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   head, tail;
   logic [PTR_W:0]     count_q;
   logic               full, empty, enq, deq;
   logic [ENTRY_W-1:0] in_ent, hd;
   logic [DATA_W-1:0]  in_d [NSLOT];
   logic [ADDR_W-1:0]  in_a [NSLOT];
   logic [DATA_W-1:0]  h_d  [NSLOT];
   logic [ADDR_W-1:0]  h_a  [NSLOT];
   logic [NSLOT-1:0]   h_ld, h_seg;
   logic [DEPTH-1:0]   hits, occ;

   assign full  = count_q == (PTR_W+1)'(DEPTH);
   assign empty = count_q == '0;
   assign enq   = valid_in & ~full & ~flush;
   assign deq   = ~empty & ~wb_hold & ~flush;

   assign in_d[0] = res_data1;
   assign in_d[1] = res_data2;
   assign in_d[2] = res_data3;
   assign in_d[3] = res_data4;
   assign in_a[0] = res_addr1;
   assign in_a[1] = res_addr2;
   assign in_a[2] = res_addr3;
   assign in_a[3] = res_addr4;

   always_comb begin
      in_ent = '0;
      for (int s = 0; s < NSLOT; s++) begin
         in_ent[slot_base(s)+SLOT_DATA +: DATA_W] = in_d[s];
         in_ent[slot_base(s)+SLOT_ADDR +: ADDR_W] = in_a[s];
         in_ent[slot_base(s)+SLOT_SEG]            = res_is_seg[s];
         in_ent[slot_base(s)+SLOT_LD]             = res_ld[s];
      end
      in_ent[OPSIZE_LO +: 2]      = opsize_in;
      in_ent[PTCID_LO +: PTCID_W] = ptcid_in;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      end else if (flush) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         if (enq) begin
            mem[tail] <= in_ent;
            tail      <= tail + 1'b1;
         end
         if (deq) head <= head + 1'b1;
         if (enq && !deq)      count_q <= count_q + 1'b1;
         else if (deq && !enq) count_q <= count_q - 1'b1;
      end
   end

   assign hd = mem[head];

   always_comb begin
      for (int s = 0; s < NSLOT; s++) begin
         h_d[s]   = hd[slot_base(s)+SLOT_DATA +: DATA_W];
         h_a[s]   = hd[slot_base(s)+SLOT_ADDR +: ADDR_W];
         h_seg[s] = hd[slot_base(s)+SLOT_SEG];
         h_ld[s]  = hd[slot_base(s)+SLOT_LD];
      end
   end

   assign wb_data1      = h_d[0];
   assign wb_data2      = h_d[1];
   assign wb_data3      = h_d[2];
   assign wb_data4      = h_d[3];
   assign wb_segdata1   = h_d[0][SEG_W-1:0];
   assign wb_segdata2   = h_d[1][SEG_W-1:0];
   assign wb_segdata3   = h_d[2][SEG_W-1:0];
   assign wb_segdata4   = h_d[3][SEG_W-1:0];
   assign wb_addr1      = h_a[0];
   assign wb_addr2      = h_a[1];
   assign wb_addr3      = h_a[2];
   assign wb_addr4      = h_a[3];
   assign wb_segaddr1   = h_a[0];
   assign wb_segaddr2   = h_a[1];
   assign wb_segaddr3   = h_a[2];
   assign wb_segaddr4   = h_a[3];
   assign wb_opsize     = hd[OPSIZE_LO +: 2];
   assign wb_inst_ptcid = hd[PTCID_LO +: PTCID_W];
   assign wb_regld      = {NSLOT{deq}} & h_ld & ~h_seg;
   assign wb_segld      = {NSLOT{deq}} & h_ld & h_seg;
   assign stall_out     = valid_in & full;
   assign count         = count_q;

   // Occupancy is by distance from head, so the draining head still counts.
   for (genvar k = 0; k < DEPTH; k++) begin : g_match
      logic [NSLOT*ADDR_W-1:0] e_addr;
      logic [NSLOT-1:0]        e_seg, e_ld;
      logic [PTR_W-1:0]        off;

      always_comb begin
         for (int s = 0; s < NSLOT; s++) begin
            e_addr[s*ADDR_W +: ADDR_W] = mem[k][slot_base(s)+SLOT_ADDR +: ADDR_W];
            e_seg[s] = mem[k][slot_base(s)+SLOT_SEG];
            e_ld[s]  = mem[k][slot_base(s)+SLOT_LD];
         end
      end

      assign off    = PTR_W'(k) - head;
      assign occ[k] = {1'b0, off} < count_q;

      wbq_match u_match (
         .addr       (e_addr),
         .is_seg     (e_seg),
         .ld         (e_ld),
         .rd_regaddr (rd_regaddr),
         .rd_segaddr (rd_segaddr),
         .hit        (hits[k])
      );
   end

   assign fwd_stall = rd_valid & |(hits & occ);

endmodule
